// File: rtl/byte_capture_fifo.sv
// Samples the latched upstream byte on every enable and buffers it in a small FIFO
// behind a valid/ready stream; overflow drops are counted. Option: BYTE_CAPTURE_CHANGE_ONLY_EN.
module byte_capture_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                         i_clk,
   input  logic                         i_arst,
   input  logic                         i_en,
   input  logic [DW-1:0]                i_d,
   output logic [DW-1:0]                o_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [7:0]                   o_drop_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [7:0]    DROP_MAX = 8'hFF;

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic [7:0]    drop_cnt_r;
   logic          attempt_s;
   logic          push_s;
   logic          pop_s;
   logic          drop_s;
   logic          full_s;
   logic          empty_s;

   assign full_s  = (count_r == CNT_FULL);
   assign empty_s = (count_r == CNT_ZERO);

`ifdef BYTE_CAPTURE_CHANGE_ONLY_EN
   logic [DW-1:0] last_sample_r;
   logic          last_valid_r;

   // A byte equal to the previous attempt is suppressed rather than treated as a drop.
   assign attempt_s = i_en && (!last_valid_r || (i_d != last_sample_r));

   // Remember the last qualified attempt, whether it was stored or dropped.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         last_sample_r <= {DW{1'b0}};
         last_valid_r  <= 1'b0;
      end else if (attempt_s) begin
         last_sample_r <= i_d;
         last_valid_r  <= 1'b1;
      end else begin
         last_sample_r <= last_sample_r;
         last_valid_r  <= last_valid_r;
      end
   end
`else
   assign attempt_s = i_en;
`endif

   // A pop frees a slot in the same cycle, so a full FIFO still accepts when popped.
   assign pop_s  = !empty_s && i_ready;
   assign push_s = attempt_s && (!full_s || pop_s);
   assign drop_s = attempt_s && full_s && !pop_s;

   // Occupancy update from the push/pop pair.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage, pointers, occupancy and the saturating drop counter.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DW{1'b0}};
         end
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= CNT_ZERO;
         drop_cnt_r <= 8'h00;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= i_d;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_nxt_s;
         if (drop_s && (drop_cnt_r != DROP_MAX)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end
      end
   end

   assign o_data     = mem_r[rd_ptr_r];
   assign o_valid    = !empty_s;
   assign o_empty    = empty_s;
   assign o_full     = full_s;
   assign o_count    = count_r;
   assign o_drop_cnt = drop_cnt_r;

endmodule
